// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- multi-cycle 32-bit integer divider (DIV / DIVU)
//
// Restoring shift-subtract divider producing one quotient bit per cycle.
// Operands are captured on the edge that accepts start_i. The divider then
// runs for 32 cycles and applies the sign fix-up in a single cycle. Lo receives
// the quotient and Hi the remainder. Signed division truncates toward zero,
// and the remainder takes the sign of the dividend.
//
// Ports
//   clk_i       rising-edge clock
//   rst_i       synchronous active-high reset
//   start_i     request a division (honoured only in IDLE)
//   signed_i    1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
//   a_i         dividend; sampled with start_i
//   b_i         divisor; sampled with start_i
//   hi_o        remainder register
//   lo_o        quotient register
//   busy_o      high in every state except IDLE
//   done_o      one-cycle completion pulse (state DONE)
//   div_zero_o  one-cycle pulse alongside done_o when the divisor was zero
// -----------------------------------------------------------------------------
module div_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        div_zero_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state_q,    state_d;
  logic [5:0]  cnt_q,      cnt_d;
  logic        signed_q,   signed_d;
  logic        a_neg_q,    a_neg_d;
  logic        b_neg_q,    b_neg_d;
  logic [31:0] divisor_q,  divisor_d;
  // quot_q starts out holding the dividend magnitude. Each cycle it shifts
  // left: the dividend MSB leaves at the top and a new quotient bit enters at
  // the bottom. After 32 steps the register holds only the quotient.
  logic [31:0] quot_q,     quot_d;
  // The remainder is always smaller than the divisor, so 32 bits hold it. The
  // 33rd bit exists only in the shifted value used for the trial subtraction.
  logic [31:0] rem_q,      rem_d;
  logic [31:0] hi_q,       hi_d;
  logic [31:0] lo_q,       lo_d;
  logic        div_zero_q, div_zero_d;

  logic [32:0] shifted;
  logic [33:0] diff;
  logic        q_bit;
  logic        neg_quot;
  logic        neg_rem;

  // Trial subtraction on the 33-bit shifted partial remainder. diff[33] is
  // the borrow, so it is clear exactly when the result is non-negative.
  always_comb begin
    shifted = {rem_q, quot_q[31]};
    diff    = {1'b0, shifted} - {2'b00, divisor_q};
    q_bit   = ~diff[33];
  end

  assign neg_quot = signed_q & (a_neg_q ^ b_neg_q);
  assign neg_rem  = signed_q & a_neg_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    signed_d   = signed_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          signed_d  = signed_i;
          a_neg_d   = a_i[31];
          b_neg_d   = b_i[31];
          // The magnitude of 0x80000000 is 0x80000000, which is still
          // correct when read as an unsigned 32-bit value.
          quot_d    = (signed_i && a_i[31]) ? (32'd0 - a_i) : a_i;
          divisor_d = (signed_i && b_i[31]) ? (32'd0 - b_i) : b_i;
          rem_d     = 32'd0;
          cnt_d     = 6'd0;
          if (b_i == 32'd0) begin
            // Skip the iteration entirely. Hi/Lo stay untouched.
            state_d    = ST_DONE;
            div_zero_d = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        rem_d  = q_bit ? diff[31:0] : shifted[31:0];
        quot_d = {quot_q[30:0], q_bit};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        lo_d    = neg_quot ? (32'd0 - quot_q) : quot_q;
        hi_d    = neg_rem  ? (32'd0 - rem_q)  : rem_q;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        // start_i is deliberately ignored here. Only IDLE accepts work.
        state_d    = ST_IDLE;
        div_zero_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 6'd0;
      signed_q   <= 1'b0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      divisor_q  <= 32'd0;
      quot_q     <= 32'd0;
      rem_q      <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      signed_q   <= signed_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);
  assign div_zero_o = div_zero_q;

endmodule
